// File: rtl/npu_pkg.sv
// Shared constants and FSM state type for the NPU classifier blocks.
package npu_pkg;

  localparam int unsigned IN_H   = 12;
  localparam int unsigned IN_W   = 11;
  localparam int unsigned N_CLS  = 10;
  localparam int unsigned FEAT_W = 24;
  localparam int unsigned W_W    = 8;
  localparam int unsigned ACC_W  = 40;
  localparam int unsigned N_FEAT = IN_H * IN_W;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    CMP
  } fc_state_e;

endpackage

// File: rtl/fc_mac.sv
// Registered signed multiply-accumulate with synchronous clear.
module fc_mac #(
  parameter int unsigned A_W   = 24,
  parameter int unsigned B_W   = 8,
  parameter int unsigned ACC_W = 40
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr_i,
  input  logic                    en_i,
  input  logic signed [A_W-1:0]   a_i,
  input  logic signed [B_W-1:0]   b_i,
  output logic signed [ACC_W-1:0] acc_o
);

  logic signed [A_W+B_W-1:0] prod;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W-1:0]   acc_q;

  // Full-precision product, sign-extended to the accumulator width.
  assign prod     = a_i * b_i;
  assign prod_ext = {{(ACC_W-A_W-B_W){prod[A_W+B_W-1]}}, prod};

  // Accumulator: clear has priority over accumulate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (clr_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_q + prod_ext;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/fc_argmax.sv
// Fully-connected classifier head: serial MAC over a captured feature map,
// then argmax over class scores (ties keep the lowest class index).
module fc_argmax #(
  parameter int unsigned IN_H   = npu_pkg::IN_H,
  parameter int unsigned IN_W   = npu_pkg::IN_W,
  parameter int unsigned N_CLS  = npu_pkg::N_CLS,
  parameter int unsigned FEAT_W = npu_pkg::FEAT_W,
  parameter int unsigned W_W    = npu_pkg::W_W,
  parameter int unsigned ACC_W  = npu_pkg::ACC_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic signed [FEAT_W-1:0]    in_feat [IN_H][IN_W],
  input  logic signed [W_W-1:0]       w_fc [N_CLS][IN_H*IN_W],
  output logic                        busy,
  output logic                        out_valid,
  output logic [$clog2(N_CLS)-1:0]    class_idx,
  output logic signed [ACC_W-1:0]     class_score
);

  import npu_pkg::*;

  localparam int unsigned NFeat = IN_H * IN_W;
  localparam int unsigned EW    = $clog2(NFeat);
  localparam int unsigned KW    = $clog2(N_CLS);
  localparam logic [EW-1:0] ELast = EW'(NFeat - 1);
  localparam logic [KW-1:0] KLast = KW'(N_CLS - 1);

  fc_state_e                state_q;
  logic                     prev_valid_q;
  logic [EW-1:0]            e_q;
  logic [KW-1:0]            k_q;
  logic signed [ACC_W-1:0]  best_score_q;
  logic [KW-1:0]            best_idx_q;
  logic signed [FEAT_W-1:0] feat_buf_q [NFeat];

  logic                     start;
  logic                     mac_en;
  logic                     mac_clr;
  logic signed [ACC_W-1:0]  acc;
  logic                     take;
  logic signed [ACC_W-1:0]  best_score_d;
  logic [KW-1:0]            best_idx_d;

  // A start is a rising edge of in_valid seen while idle.
  assign start   = (state_q == IDLE) && in_valid && !prev_valid_q;
  assign mac_en  = (state_q == MAC);
  assign mac_clr = start || (state_q == CMP);

  fc_mac #(
    .A_W   (FEAT_W),
    .B_W   (W_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .clr_i (mac_clr),
    .en_i  (mac_en),
    .a_i   (feat_buf_q[e_q]),
    .b_i   (w_fc[k_q][e_q]),
    .acc_o (acc)
  );

  // Running argmax including the class finishing this cycle.
  always_comb begin
    take         = (k_q == '0) || (acc > best_score_q);
    best_score_d = take ? acc : best_score_q;
    best_idx_d   = take ? k_q : best_idx_q;
  end

  // Feature snapshot taken on the start edge; not reset since it is only read after a capture.
  always_ff @(posedge clk) begin
    if (start) begin
      for (int r = 0; r < int'(IN_H); r++) begin
        for (int c = 0; c < int'(IN_W); c++) begin
          feat_buf_q[r*IN_W+c] <= in_feat[r][c];
        end
      end
    end
  end

  // Control FSM, counters, argmax registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      prev_valid_q <= 1'b0;
      e_q          <= '0;
      k_q          <= '0;
      best_score_q <= '0;
      best_idx_q   <= '0;
      busy         <= 1'b0;
      out_valid    <= 1'b0;
      class_idx    <= '0;
      class_score  <= '0;
    end else begin
      prev_valid_q <= in_valid;
      out_valid    <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            e_q     <= '0;
            k_q     <= '0;
            busy    <= 1'b1;
            state_q <= MAC;
          end
        end
        MAC: begin
          if (e_q == ELast) begin
            state_q <= CMP;
          end else begin
            e_q <= e_q + 1'b1;
          end
        end
        CMP: begin
          best_score_q <= best_score_d;
          best_idx_q   <= best_idx_d;
          e_q          <= '0;
          if (k_q != KLast) begin
            k_q     <= k_q + 1'b1;
            state_q <= MAC;
          end else begin
            class_idx   <= best_idx_d;
            class_score <= best_score_d;
            out_valid   <= 1'b1;
            busy        <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_argmax.sv
// Self-checking bench for fc_argmax: directed cases plus random runs
// checked against a plain dot-product/argmax model.
module tb_fc_argmax;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic signed [23:0] feat [12][11];
  logic signed [7:0]  w [10][132];
  logic               busy;
  logic               out_valid;
  logic [3:0]         class_idx;
  logic signed [39:0] class_score;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fc_argmax dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_feat     (feat),
    .w_fc        (w),
    .busy        (busy),
    .out_valid   (out_valid),
    .class_idx   (class_idx),
    .class_score (class_score)
  );

  // Reference: plain dot products and a strict-greater argmax.
  function automatic void model(output int idx, output longint score);
    longint s;
    idx   = 0;
    score = 0;
    for (int k = 0; k < 10; k++) begin
      s = 0;
      for (int r = 0; r < 12; r++)
        for (int c = 0; c < 11; c++)
          s += longint'(feat[r][c]) * longint'(w[k][r*11+c]);
      if (k == 0 || s > score) begin
        score = s;
        idx   = k;
      end
    end
  endfunction

  task automatic fill(input int fv, input int wv);
    for (int r = 0; r < 12; r++)
      for (int c = 0; c < 11; c++) feat[r][c] = 24'(fv);
    for (int k = 0; k < 10; k++)
      for (int i = 0; i < 132; i++) w[k][i] = 8'(wv);
  endtask

  task automatic randomize_all();
    for (int r = 0; r < 12; r++)
      for (int c = 0; c < 11; c++) feat[r][c] = 24'($urandom);
    for (int k = 0; k < 10; k++)
      for (int i = 0; i < 132; i++) w[k][i] = 8'($urandom);
  endtask

  // Launch one run and observe it; features are scrambled after capture.
  task automatic do_run(input int retrig_at, output int lat, output int pulses,
                        output logic b_first, output logic b_last, output logic b_done);
    lat = -1;
    pulses = 0;
    b_first = 1'b0;
    b_last = 1'b0;
    b_done = 1'b1;
    @(negedge clk) in_valid = 1'b0;
    @(negedge clk) in_valid = 1'b1;
    @(posedge clk);
    #1;
    for (int r = 0; r < 12; r++)
      for (int c = 0; c < 11; c++) feat[r][c] = 24'($urandom);
    for (int n = 1; n <= 1700; n++) begin
      @(posedge clk);
      #1;
      if (n == 3) in_valid = 1'b0;
      if (n == retrig_at) in_valid = 1'b1;
      if (n == retrig_at + 4) in_valid = 1'b0;
      if (n == 1) b_first = busy;
      if (n == 1329) b_last = busy;
      if (n == 1330) b_done = busy;
      if (out_valid) begin
        pulses++;
        if (lat < 0) lat = n;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    fill(0, 0);
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, out_valid} !== 2'b00 || class_idx !== 4'd0 || class_score !== 40'sd0) begin
      n_bad++;
      $display("FAIL reset_held: busy=%b ov=%b idx=%0d score=%0d want 0 0 0 0",
               busy, out_valid, class_idx, class_score);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy, out_valid} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_idle: busy=%b ov=%b want 0 0", busy, out_valid);
    end
  endtask

  task automatic test_ones();
    int lat, pulses;
    logic b1, b2, b3;
    fill(1, 0);
    for (int k = 0; k < 10; k++)
      for (int i = 0; i < 132; i++) w[k][i] = 8'(k - 5);
    do_run(0, lat, pulses, b1, b2, b3);
    n_cmp++;
    if (class_idx !== 4'd9) begin
      n_bad++; $display("FAIL ones_idx: got %0d want 9", class_idx);
    end
    n_cmp++;
    if (class_score !== 40'sd528) begin
      n_bad++; $display("FAIL ones_score: got %0d want 528", class_score);
    end
    n_cmp++;
    if (lat !== 1330) begin
      n_bad++; $display("FAIL ones_latency: got %0d want 1330", lat);
    end
    n_cmp++;
    if (pulses !== 1) begin
      n_bad++; $display("FAIL ones_pulse_width: got %0d want 1", pulses);
    end
    n_cmp++;
    if ({b1, b2, b3} !== 3'b110) begin
      n_bad++; $display("FAIL ones_busy_window: got %b want 110", {b1, b2, b3});
    end
  endtask

  task automatic test_zero_weights();
    int lat, pulses;
    logic b1, b2, b3;
    randomize_all();
    for (int k = 0; k < 10; k++)
      for (int i = 0; i < 132; i++) w[k][i] = 8'sd0;
    do_run(0, lat, pulses, b1, b2, b3);
    n_cmp++;
    if (class_idx !== 4'd0 || class_score !== 40'sd0 || pulses !== 1) begin
      n_bad++;
      $display("FAIL zero_weights: idx=%0d score=%0d pulses=%0d want 0 0 1",
               class_idx, class_score, pulses);
    end
  endtask

  task automatic test_sparse();
    int lat, pulses;
    logic b1, b2, b3;
    fill(0, 0);
    feat[3][4] = 24'sd1000;
    w[2][37] = 8'sd5;
    w[6][37] = -8'sd128;
    do_run(0, lat, pulses, b1, b2, b3);
    n_cmp++;
    if (class_idx !== 4'd2 || class_score !== 40'sd5000) begin
      n_bad++;
      $display("FAIL sparse: idx=%0d score=%0d want 2 5000", class_idx, class_score);
    end
  endtask

  task automatic test_extremes();
    int lat, pulses;
    logic b1, b2, b3;
    fill(24'h7FFFFF, -128);
    for (int i = 0; i < 132; i++) w[7][i] = 8'sd127;
    do_run(0, lat, pulses, b1, b2, b3);
    n_cmp++;
    if (class_idx !== 4'd7 || class_score !== 40'sd140626607748) begin
      n_bad++;
      $display("FAIL extremes: idx=%0d score=%0d want 7 140626607748", class_idx, class_score);
    end
  endtask

  task automatic test_random();
    int lat, pulses, e_idx;
    longint e_score;
    logic b1, b2, b3;
    for (int t = 0; t < 4; t++) begin
      randomize_all();
      model(e_idx, e_score);
      do_run(0, lat, pulses, b1, b2, b3);
      n_cmp++;
      if (int'(class_idx) !== e_idx || longint'(class_score) !== e_score) begin
        n_bad++;
        $display("FAIL random_%0d: idx=%0d score=%0d want %0d %0d",
                 t, class_idx, class_score, e_idx, e_score);
      end
      n_cmp++;
      if (lat !== 1330 || pulses !== 1) begin
        n_bad++;
        $display("FAIL random_timing_%0d: lat=%0d pulses=%0d want 1330 1", t, lat, pulses);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat, pulses, e_idx;
    longint e_score;
    logic b1, b2, b3;
    randomize_all();
    model(e_idx, e_score);
    do_run(200, lat, pulses, b1, b2, b3);
    n_cmp++;
    if (pulses !== 1 || lat !== 1330) begin
      n_bad++;
      $display("FAIL retrigger_ignored: pulses=%0d lat=%0d want 1 1330", pulses, lat);
    end
    n_cmp++;
    if (int'(class_idx) !== e_idx || longint'(class_score) !== e_score) begin
      n_bad++;
      $display("FAIL retrigger_result: idx=%0d score=%0d want %0d %0d",
               class_idx, class_score, e_idx, e_score);
    end
  endtask

  task automatic test_reset_midrun();
    int lat, pulses, e_idx, seen;
    longint e_score;
    logic b1, b2, b3;
    randomize_all();
    @(negedge clk) in_valid = 1'b0;
    @(negedge clk) in_valid = 1'b1;
    @(posedge clk);
    repeat (500) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy, out_valid} !== 2'b00 || class_idx !== 4'd0 || class_score !== 40'sd0) begin
      n_bad++;
      $display("FAIL midrun_reset: busy=%b ov=%b idx=%0d score=%0d want 0 0 0 0",
               busy, out_valid, class_idx, class_score);
    end
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    seen = 0;
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      if (out_valid || busy) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_bad++; $display("FAIL aborted_run_silent: active cycles=%0d want 0", seen);
    end
    randomize_all();
    model(e_idx, e_score);
    do_run(0, lat, pulses, b1, b2, b3);
    n_cmp++;
    if (int'(class_idx) !== e_idx || longint'(class_score) !== e_score ||
        lat !== 1330 || pulses !== 1) begin
      n_bad++;
      $display("FAIL after_reset_run: idx=%0d score=%0d lat=%0d pulses=%0d want %0d %0d 1330 1",
               class_idx, class_score, lat, pulses, e_idx, e_score);
    end
  endtask

  initial begin
    test_reset();
    test_ones();
    test_zero_weights();
    test_sparse();
    test_extremes();
    test_random();
    test_back_to_back();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
